// File: rtl/nv_ram_rws_256x256_rd_arb.sv
// rtl/nv_ram_rws_256x256_rd_arb.sv - two-client round-robin read arbiter and response stage for a 256x256 1R1W RAM
module nv_ram_rws_256x256_rd_arb #(
  parameter int AW = 8,
  parameter int DW = 256
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          rd0_req_pvld,
  output logic          rd0_req_prdy,
  input  logic [AW-1:0] rd0_req_pd,
  input  logic          rd1_req_pvld,
  output logic          rd1_req_prdy,
  input  logic [AW-1:0] rd1_req_pd,
  output logic          rd0_rsp_pvld,
  input  logic          rd0_rsp_prdy,
  output logic          rd1_rsp_pvld,
  input  logic          rd1_rsp_prdy,
  output logic [DW-1:0] rsp_pd,
  input  logic          wr_req_pvld,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          arb_idle
);

  logic          s1_vld_q, s1_vld_d;
  logic          s1_tag_q, s1_tag_d;
  logic          s2_vld_q, s2_vld_d;
  logic          s2_tag_q, s2_tag_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic          last_gnt_q, last_gnt_d;

  logic          s2_acc;
  logic          s1_adv;
  logic          issue_ok;
  logic          winner;
  logic          winner_pvld;
  logic          grant;

  // Response handshake and pipeline advance conditions
  assign s2_acc   = s2_vld_q & (s2_tag_q ? rd1_rsp_prdy : rd0_rsp_prdy);
  assign s1_adv   = ~s2_vld_q | s2_acc;
  assign issue_ok = (~s1_vld_q | s1_adv) & nvdla_core_rstn;

  // Round-robin winner: a lone requester wins, otherwise the client not granted last
  always_comb begin
    winner = ~last_gnt_q;
    if (rd0_req_pvld & ~rd1_req_pvld) begin
      winner = 1'b0;
    end else if (rd1_req_pvld & ~rd0_req_pvld) begin
      winner = 1'b1;
    end
  end

  assign winner_pvld  = winner ? rd1_req_pvld : rd0_req_pvld;
  assign rd0_req_prdy = issue_ok & ~winner;
  assign rd1_req_prdy = issue_ok & winner;
  assign grant        = issue_ok & winner_pvld;

  assign ram_re = grant;
  assign ram_ra = winner ? rd1_req_pd : rd0_req_pd;

  // Writes bypass the arbiter entirely
  assign ram_we = wr_req_pvld;
  assign ram_wa = wr_req_addr;
  assign ram_di = wr_req_data;

  assign rd0_rsp_pvld = s2_vld_q & ~s2_tag_q;
  assign rd1_rsp_pvld = s2_vld_q & s2_tag_q;
  assign rsp_pd       = s2_data_q;
  assign arb_idle     = ~s1_vld_q & ~s2_vld_q;

  // Next-state for s1/s2 and the round-robin pointer; reload wins over clear
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_tag_d   = s1_tag_q;
    s2_vld_d   = s2_vld_q;
    s2_tag_d   = s2_tag_q;
    s2_data_d  = s2_data_q;
    last_gnt_d = last_gnt_q;
    if (s1_vld_q & s1_adv) begin
      s2_vld_d  = 1'b1;
      s2_tag_d  = s1_tag_q;
      s2_data_d = ram_dout;
      s1_vld_d  = 1'b0;
    end else if (s2_acc) begin
      s2_vld_d = 1'b0;
    end
    if (grant) begin
      s1_vld_d   = 1'b1;
      s1_tag_d   = winner;
      last_gnt_d = winner;
    end
  end

  // Pipeline and pointer registers; reset drops anything in flight
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld_q   <= 1'b0;
      s1_tag_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= 1'b0;
      s2_data_q  <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_tag_q   <= s1_tag_d;
      s2_vld_q   <= s2_vld_d;
      s2_tag_q   <= s2_tag_d;
      s2_data_q  <= s2_data_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: doc/nv_ram_rws_256x256_rd_arb.md
# nv_ram_rws_256x256_rd_arb

Read arbiter and response sequencer for one 256x256 1R1W RAM with a registered read address. It shares the RAM read port between two read clients using round-robin arbitration. It returns read data through a registered, back-pressurable response stage. The single write client passes straight through to the RAM write port. It sits between the consuming datapath units and the RAM instance, and owns all RAM read/write port signals.

## Interface
- AW, 8, RAM address width (256 entries)
- DW, 256, RAM data width
- nvdla_core_clk  in  1  core clock; the block and the RAM both use it
- nvdla_core_rstn  in  1  asynchronous, active-low reset
- rd0_req_pvld / rd1_req_pvld  in  1  read request valid, client 0/1
- rd0_req_prdy / rd1_req_prdy  out  1  read request accepted, client 0/1
- rd0_req_pd / rd1_req_pd  in  AW  read address, client 0/1
- rd0_rsp_pvld / rd1_rsp_pvld  out  1  response valid, client 0/1 (at most one high)
- rd0_rsp_prdy / rd1_rsp_prdy  in  1  response ready, client 0/1
- rsp_pd  out  DW  shared response data
- wr_req_pvld  in  1  write valid; always accepted, no ready
- wr_req_addr  in  AW  write address
- wr_req_data  in  DW  write data
- ram_re / ram_ra  out  1 / AW  RAM read enable / read address
- ram_dout  in  DW  RAM read data; valid the cycle after ram_re, held until the next ram_re
- ram_we / ram_wa / ram_di  out  1 / AW / DW  RAM write port
- arb_idle  out  1  no request in flight and no response pending

## Operation
- Pipeline has two stages:
  - s1 holds one issued read: s1_vld and s1_tag (client id).
  - s2 is the response register: s2_vld, s2_tag and the DW-bit data driving rsp_pd.
- issue_ok = !s1_vld | s1_adv, where s1_adv = !s2_vld | s2_acc.
- s2_acc = s2_vld & rdN_rsp_prdy, for N = s2_tag.
- Arbitration:
  - The winner is the requesting client if only one is requesting.
  - If both request, the winner is the client not granted last; pointer last_gnt.
  - rdN_req_prdy = issue_ok & (winner == N). It is combinational and may depend on rdN_req_pvld.
- Grant = pvld & prdy of the winner. On a grant:
  - ram_re = 1 and ram_ra = winner address.
  - s1 loads {1, winner}.
  - last_gnt updates to the winner.
- s1 advance: when s1_vld & s1_adv, s2 loads {1, s1_tag, ram_dout}. If no new grant occurs in the same cycle, s1 clears.
- s1 stall: when s1_vld & !s1_adv, s1 holds, ram_re = 0 and ram_ra is don't-care. The RAM keeps its read address, so ram_dout keeps tracking the same entry.
- s2 clear: when s2_acc and s2 is not reloaded in the same cycle, s2 clears.
- rdN_rsp_pvld = s2_vld & (s2_tag == N).
- Write path is combinational pass-through: ram_we = wr_req_pvld, ram_wa = wr_req_addr, ram_di = wr_req_data. Writes are never blocked.
- Data coherence: a response returns the RAM content at the cycle s1 advances into s2, so it includes every write whose wr_req_pvld cycle precedes that capture cycle.
  - A write in the grant cycle to the same address is visible in the response.
  - A write in the capture cycle is not visible.
  - During an s1 stall, writes to the stalled address are visible.
- arb_idle = !s1_vld & !s2_vld.

## Timing
- Reset values:
  - s1_vld = 0, s2_vld = 0, rsp_pd = 0.
  - last_gnt = 1, so client 0 wins the first contended cycle.
  - All rsp_pvld = 0, ram_re = 0, arb_idle = 1.
  - ram_we follows wr_req_pvld.
- Latency: grant at cycle N gives response pvld at N+2 when s2 is free at N+1.
- Throughput: one grant per cycle while responses are accepted on arrival.
- Back-pressure depth: at most 2 reads in flight (s1 + s2). With the response held and s1 full, both req_prdy are 0.
- Simultaneous events:
  - s2 accept, s1 advance and a new grant can all occur in one cycle.
  - s2 reload takes priority over s2 clear.
- Reset mid-operation: in-flight reads and the pending response are discarded; no response is issued after reset deasserts.
- rdN_req_prdy is 0 while nvdla_core_rstn is low.

## Test plan
- Single read:
  - Stimulus: write 0xA5 repeated to addr 0x10, then client 0 reads 0x10 at cycle N with rsp_prdy=1.
  - Required: ram_re=1, ram_ra=0x10 at N; rd0_rsp_pvld=1 at N+2 with rsp_pd = 0xA5 repeated; arb_idle=1 at N+3.
- Contention:
  - Stimulus: both clients request continuously after reset with rsp_prdy=1.
  - Required: grants alternate 0,1,0,1; one grant per cycle; responses arrive in grant order with correct tags.
- Back-pressure:
  - Stimulus: rd0_rsp_prdy=0 with client 0 issuing reads to 0x01 then 0x02.
  - Required: two grants, then req_prdy=0. rsp_pd holds data(0x01) until prdy=1, then data(0x02) follows the next cycle.
- Write coherence:
  - Stimulus: read 0x20 at N while writing 0x20 = X in cycle N; then read 0x21 at M while writing 0x21 = Y in cycle M+1.
  - Required: first response = X; second response = the old value of 0x21.
- Reset mid-flight:
  - Stimulus: assert nvdla_core_rstn low one cycle after a grant.
  - Required: all outputs return to reset values immediately; no rsp_pvld after release; the next contended grant goes to client 0.
